// File: rtl/lod_expand.sv
// lod_expand: rebuilds a WIDTH-bit magnitude from a truncated mantissa and the
// leading-one position reported by the detector. Two-stage valid/ready pipeline
// with full backpressure.
// Optional feature macro: LOD_COMP_FILL_EN (half-LSB fill of truncated bits).
module lod_expand #(
    parameter int WIDTH = 16,
    parameter int MW    = 8,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MW-1:0]    in_mant,
    input  logic [PW-1:0]    in_pos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    logic             v1;
    logic [MW-1:0]    mant1;
    logic [PW-1:0]    s1;
    logic             err1;
    logic             adv1;
    logic             adv2;
    logic [PW-1:0]    s_in;
    logic             err_in;
    logic [WIDTH-1:0] data_nx;

    // Stage advance: a stage moves when it is empty or the next stage moves
    always_comb begin
        adv2     = !out_valid || out_ready;
        adv1     = !v1 || adv2;
        in_ready = adv1;
    end

    // Input decode: shift amount and malformed-input detection
    always_comb begin
        logic above;
        logic hit;
        s_in   = '0;
        err_in = 1'b0;
        above  = 1'b0;
        hit    = 1'b0;
        for (int unsigned i = 0; i < MW; i++) begin
            if (i > 32'(in_pos)) above = above | in_mant[i];
            if (i == 32'(in_pos)) hit = in_mant[i];
        end
        if (in_pos >= PW'(MW - 1)) begin
            s_in   = in_pos - PW'(MW - 1);
            err_in = !in_mant[MW-1];
        end else begin
            err_in = above || !hit;
        end
        // A zero mantissa carries no position information, so it is never malformed
        if (in_mant == '0) err_in = 1'b0;
    end

    // Stage 2 result: mantissa shifted back into place, optional half-LSB fill
    always_comb begin
        data_nx = WIDTH'(mant1) << s1;
`ifdef LOD_COMP_FILL_EN
        if (s1 != '0 && mant1 != '0) data_nx = data_nx | (WIDTH'(1) << (s1 - PW'(1)));
`endif
    end

    // Stage 1 register: capture mantissa, shift amount and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            mant1 <= '0;
            s1    <= '0;
            err1  <= 1'b0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                mant1 <= in_mant;
                s1    <= s_in;
                err1  <= err_in;
            end
        end
    end

    // Stage 2 register: output beat, held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (adv2) begin
            out_valid <= v1;
            if (v1) begin
                out_data <= data_nx;
                out_err  <= err1;
            end
        end
    end

endmodule

// File: tb/tb_lod_expand.sv
// tb_lod_expand: directed vectors with a scoreboard queue; a negedge monitor
// pops and compares every accepted output beat and checks stall stability.
module tb_lod_expand;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_mant = '0;
    logic [3:0]  in_pos = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_err;

    int applied = 0;
    int miscompares = 0;
    logic [16:0] expq[$];
    logic        stalled = 1'b0;
    logic [15:0] held_d = '0;
    logic        held_e = 1'b0;

    logic [7:0]  vm [12];
    logic [3:0]  vp [12];
    logic [15:0] vd [12];
    logic        ve [12];

    always #5 clk = ~clk;

    lod_expand #(.WIDTH(16), .MW(8), .PW(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_pos(in_pos),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare each accepted beat against the scoreboard, check hold while stalled
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled && out_valid) begin
                chk("hold_data", 32'(out_data), 32'(held_d));
                chk("hold_err", 32'(out_err), 32'(held_e));
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_beat", 32'(out_data), 32'hDEAD_BEEF);
                end else begin
                    e = expq.pop_front();
                    chk("out_data", 32'(out_data), 32'(e[16:1]));
                    chk("out_err", 32'(out_err), 32'(e[0]));
                end
            end
            stalled = out_valid && !out_ready;
            held_d  = out_data;
            held_e  = out_err;
        end
    end

    task automatic send(input int idx);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_mant  = vm[idx];
        in_pos   = vp[idx];
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        expq.push_back({vd[idx], ve[idx]});
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1 chk("drain", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        // mant, pos, expected data, expected err
        vm[0]  = 8'hB5; vp[0]  = 4'd15; ve[0]  = 1'b0;
        vm[1]  = 8'h80; vp[1]  = 4'd10; ve[1]  = 1'b0;
        vm[2]  = 8'h9A; vp[2]  = 4'd7;  ve[2]  = 1'b0; vd[2]  = 16'h009A;
        vm[3]  = 8'h05; vp[3]  = 4'd2;  ve[3]  = 1'b0; vd[3]  = 16'h0005;
        vm[4]  = 8'h00; vp[4]  = 4'd9;  ve[4]  = 1'b0; vd[4]  = 16'h0000;
        vm[5]  = 8'h40; vp[5]  = 4'd12; ve[5]  = 1'b1;
        vm[6]  = 8'hFF; vp[6]  = 4'd7;  ve[6]  = 1'b0; vd[6]  = 16'h00FF;
        vm[7]  = 8'h01; vp[7]  = 4'd0;  ve[7]  = 1'b0; vd[7]  = 16'h0001;
        vm[8]  = 8'h03; vp[8]  = 4'd0;  ve[8]  = 1'b1; vd[8]  = 16'h0003;
        vm[9]  = 8'hC0; vp[9]  = 4'd8;  ve[9]  = 1'b0;
        vm[10] = 8'hF0; vp[10] = 4'd11; ve[10] = 1'b0;
        vm[11] = 8'h12; vp[11] = 4'd4;  ve[11] = 1'b0; vd[11] = 16'h0012;
`ifdef LOD_COMP_FILL_EN
        vd[0] = 16'hB580; vd[1] = 16'h0404; vd[5] = 16'h0810;
        vd[9] = 16'h0181; vd[10] = 16'h0F08;
`else
        vd[0] = 16'hB500; vd[1] = 16'h0400; vd[5] = 16'h0800;
        vd[9] = 16'h0180; vd[10] = 16'h0F00;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency: out_valid two edges after presentation
        send(0);
        chk("lat_edge1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 chk("lat_edge2", 32'(out_valid), 32'd1);

        // Back-to-back directed vectors
        for (int i = 1; i < 12; i++) send(i);
        drain();

        // Stall: 4 beats, out_ready low for 5 cycles
        fork
            begin
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                send(5);
                send(9);
                @(negedge clk);
                chk("in_ready_full", 32'(in_ready), 32'd0);
                send(10);
                send(8);
            end
        join
        drain();

        // Full pipeline, simultaneous output and input
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(1);
        send(3);
        out_ready = 1'b1;
        send(6);
        @(negedge clk);
        chk("no_bubble", 32'(out_valid), 32'd1);
        drain();

        // Reset with 2 beats in flight
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(7);
        send(11);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        expq.delete();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("midrst_quiet", 32'(out_valid), 32'd0);

        // Recovery after reset
        send(10);
        send(2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
